multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Multi-cycle control sequencer for the processor datapath. Steps each instruction through fetch, decode, execute, memory and write-back states. Drives the ALU operand select (ALUSrc), register-file, memory and PC enables so that one ALU and one memory port are shared across cycles. Sits between the instruction register's opcode field and the datapath muxes/enables.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces IDLE
- run  in  1  1 = keep executing; sampled only at instruction boundaries
- opcode  in  6  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes current read/write this cycle
- ALUSrc  out  1  1 = ALU operand B is the sign-extended immediate; 0 = register rt
- ALUOp  out  2  00 add, 01 subtract (compare), 10 use funct
- RegDst, MemtoReg, RegWrite  out  1 each  register-file write controls
- MemRead, MemWrite, IRWrite  out  1 each  memory and IR controls
- PCWrite, PCWriteCond  out  1 each  unconditional / zero-flag-gated PC update
- PCSource  out  2  00 PC+4, 01 branch target, 10 jump target
- state  out  4  current state, for debug
- illegal_op  out  1  sticky illegal-opcode flag (macro-dependent)

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, BRANCH 6, JUMP 7, TRAP 8.
- IDLE: all outputs 0. If run=1, go to FETCH.
- FETCH: MemRead=1, PCSource=00. IRWrite and PCWrite equal mem_ready; these are the only Mealy outputs. Stay in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
- DECODE: latch the op class (R, LW, SW, ADDI, BEQ, J, ILL) into a register.
  - R/LW/SW/ADDI go to EXEC.
  - BEQ goes to BRANCH; J goes to JUMP.
  - ILL: see Configuration.
- EXEC:
  - ALUSrc=1 and ALUOp=00 for LW/SW/ADDI.
  - ALUSrc=0 and ALUOp=10 for R.
  - LW/SW go to MEM; R/ADDI go to WB.
- MEM: MemRead=1 (LW) or MemWrite=1 (SW), held while mem_ready=0.
  - On mem_ready=1, LW goes to WB.
  - On mem_ready=1, SW goes to the boundary.
- WB: RegWrite=1. RegDst=1 for R only; MemtoReg=1 for LW only. Then go to the boundary.
- BRANCH: ALUSrc=0, ALUOp=01, PCWriteCond=1, PCSource=01. Then go to the boundary.
- JUMP: PCWrite=1, PCSource=10. Then go to the boundary.
- Boundary: go to FETCH if run=1, else IDLE.
  - Deasserting run mid-instruction never aborts the instruction.
- All outputs other than IRWrite/PCWrite in FETCH are a function of state and the latched op class only.

## Timing
- Reset: asynchronous to IDLE. Every output is 0, the op class clears to ILL, and illegal_op clears. This holds from any state, including MEM with a write pending.
- Cycles per instruction with zero memory wait, counted FETCH through last state:
  - R and ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ and J: 3.
- Each cycle with mem_ready=0 in FETCH or MEM adds exactly one cycle.
- mem_ready asserted outside FETCH/MEM is ignored.
- MemRead and MemWrite are never both 1.
- RegWrite is never 1 outside WB.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - ILL in DECODE goes to TRAP, which sets illegal_op=1.
  - TRAP holds with all other outputs 0 until reset.
- Macro undefined:
  - ILL is treated as a NOP: DECODE goes to the boundary.
  - illegal_op is tied to 0.

## Structure
- Shared package ctrl_pkg holds:
  - state encodings;
  - opcode constants;
  - op-class enum;
  - ALUOp and PCSource codes.
- One sub-module, ctrl_opdecode: purely combinational opcode-to-op-class decoder, reused by the decode stage.
- The sequencer keeps the state register, the op-class register and the output decode.

## Test plan
- lw with run=1, mem_ready=1 constantly: states 1,2,3,4,5,1. ALUSrc=1 in EXEC; RegWrite=1 and MemtoReg=1 in WB only.
- R-type, then beq, with mem_ready=1:
  - R-type: ALUSrc=0, ALUOp=10 in EXEC; RegDst=1 in WB.
  - beq: ALUOp=01, PCWriteCond=1, PCSource=01 in BRANCH. Total 7 cycles.
- sw with mem_ready low for 3 MEM cycles: MemWrite held 4 cycles, then FETCH. RegWrite stays 0 throughout.
- run dropped during EXEC of addi: WB completes, then IDLE. No FETCH until run=1.
- reset pulsed mid-MEM of sw: outputs go to 0 immediately without waiting for clk; state=0.
- Opcode 111111:
  - With CTRL_ILLEGAL_TRAP_EN: TRAP (8), illegal_op=1, stuck until reset.
  - Without the macro: returns to FETCH in 3 cycles, illegal_op=0.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle control sequencer.
//   - state_t      : sequencer state encodings (exported on the debug port)
//   - OP_*         : supported opcode values (IR[31:26])
//   - opclass_t    : decoded instruction class latched in DECODE
//   - ALUOP_*/PCSRC_* : ALUOp and PCSource codes
//   - ctrl_out_t / decode_outputs : state/class-to-control decode
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_BRANCH = 4'd6,
    S_JUMP   = 4'd7,
    S_TRAP   = 4'd8
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    OC_ILL  = 3'd0,
    OC_R    = 3'd1,
    OC_LW   = 3'd2,
    OC_SW   = 3'd3,
    OC_ADDI = 3'd4,
    OC_BEQ  = 3'd5,
    OC_J    = 3'd6
  } opclass_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  // Moore part of the control word; IRWrite and the FETCH PCWrite are
  // handled separately because they follow mem_ready combinationally.
  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
  } ctrl_out_t;

  function automatic ctrl_out_t decode_outputs(input state_t st, input opclass_t oc);
    ctrl_out_t o;
    o = '0;
    case (st)
      S_FETCH: begin
        o.mem_read  = 1'b1;
        o.pc_source = PCSRC_SEQ;
      end
      S_EXEC: begin
        if (oc == OC_R) begin
          o.alu_src = 1'b0;
          o.alu_op  = ALUOP_FUNCT;
        end else begin
          o.alu_src = 1'b1;
          o.alu_op  = ALUOP_ADD;
        end
      end
      S_MEM: begin
        o.mem_read  = (oc == OC_LW);
        o.mem_write = (oc == OC_SW);
      end
      S_WB: begin
        o.reg_write  = 1'b1;
        o.reg_dst    = (oc == OC_R);
        o.mem_to_reg = (oc == OC_LW);
      end
      S_BRANCH: begin
        o.alu_src       = 1'b0;
        o.alu_op        = ALUOP_SUB;
        o.pc_write_cond = 1'b1;
        o.pc_source     = PCSRC_BR;
      end
      S_JUMP: begin
        o.pc_write  = 1'b1;
        o.pc_source = PCSRC_JMP;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: control-sequencer bus between datapath and controller.
//   Datapath -> controller : run, opcode, mem_ready
//   Controller -> datapath : ALUSrc, ALUOp, RegDst, MemtoReg, RegWrite,
//                            MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond,
//                            PCSource, state (debug), illegal_op
//   modport master : datapath / stimulus side
//   modport slave  : controller side
interface multi_cycle_ctrl_if;
  logic       run;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       ALUSrc;
  logic [1:0] ALUOp;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       PCWriteCond;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       illegal_op;

  modport master (
    output run, opcode, mem_ready,
    input  ALUSrc, ALUOp, RegDst, MemtoReg, RegWrite, MemRead, MemWrite,
           IRWrite, PCWrite, PCWriteCond, PCSource, state, illegal_op
  );

  modport slave (
    input  run, opcode, mem_ready,
    output ALUSrc, ALUOp, RegDst, MemtoReg, RegWrite, MemRead, MemWrite,
           IRWrite, PCWrite, PCWriteCond, PCSource, state, illegal_op
  );
endinterface

// File: rtl/multi_cycle_ctrl_opdecode.sv
// ctrl_opdecode: combinational opcode (IR[31:26]) to instruction-class decoder.
//   i_opcode : opcode field
//   o_class  : decoded class; anything unsupported maps to OC_ILL
module ctrl_opdecode
  import ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output opclass_t   o_class
);
  always_comb begin
    o_class = OC_ILL;
    case (i_opcode)
      OP_RTYPE: o_class = OC_R;
      OP_LW:    o_class = OC_LW;
      OP_SW:    o_class = OC_SW;
      OP_ADDI:  o_class = OC_ADDI;
      OP_BEQ:   o_class = OC_BEQ;
      OP_J:     o_class = OC_J;
      default:  o_class = OC_ILL;
    endcase
  end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB,
// BRANCH, JUMP, TRAP) driving shared-ALU / shared-memory datapath controls.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, forces IDLE and clears all outputs
//   bus   : multi_cycle_ctrl_if.slave (run/opcode/mem_ready in, controls out)
// Build option: define CTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes in
// TRAP with a sticky illegal_op; otherwise they execute as a NOP.
module multi_cycle_ctrl
  import ctrl_pkg::*;
(
  input logic              clk,
  input logic              reset,
  multi_cycle_ctrl_if.slave bus
);
  state_t    r_state;
  state_t    w_nxt_state;
  state_t    w_boundary;
  opclass_t  r_class;
  opclass_t  w_nxt_class;
  opclass_t  w_dec_class;
  ctrl_out_t r_out;
  ctrl_out_t w_nxt_out;
  logic      w_fetch_ack;

  ctrl_opdecode u_opdecode (
    .i_opcode (bus.opcode),
    .o_class  (w_dec_class)
  );

  always_comb begin
    w_boundary  = bus.run ? S_FETCH : S_IDLE;
    w_nxt_class = (r_state == S_DECODE) ? w_dec_class : r_class;
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE:  w_nxt_state = bus.run ? S_FETCH : S_IDLE;
      S_FETCH: w_nxt_state = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (w_dec_class)
          OC_R, OC_LW, OC_SW, OC_ADDI: w_nxt_state = S_EXEC;
          OC_BEQ:                      w_nxt_state = S_BRANCH;
          OC_J:                        w_nxt_state = S_JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:                     w_nxt_state = S_TRAP;
`else
          default:                     w_nxt_state = w_boundary;
`endif
        endcase
      end
      S_EXEC: w_nxt_state = (r_class == OC_LW || r_class == OC_SW) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.mem_ready)
          w_nxt_state = (r_class == OC_LW) ? S_WB : w_boundary;
      end
      S_WB, S_BRANCH, S_JUMP: w_nxt_state = w_boundary;
      S_TRAP:  w_nxt_state = S_TRAP;
      default: w_nxt_state = S_IDLE;
    endcase
    // Outputs are registered, so they are decoded from the state being entered.
    w_nxt_out = decode_outputs(w_nxt_state, w_nxt_class);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_class <= OC_ILL;
      r_out   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_class <= w_nxt_class;
      r_out   <= w_nxt_out;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_illegal <= 1'b0;
    else if (w_nxt_state == S_TRAP)
      r_illegal <= 1'b1;
  end
  assign bus.illegal_op = r_illegal;
`else
  assign bus.illegal_op = 1'b0;
`endif

  // IR load and PC+4 update happen in the cycle memory delivers the word.
  assign w_fetch_ack = (r_state == S_FETCH) && bus.mem_ready;

  assign bus.ALUSrc      = r_out.alu_src;
  assign bus.ALUOp       = r_out.alu_op;
  assign bus.RegDst      = r_out.reg_dst;
  assign bus.MemtoReg    = r_out.mem_to_reg;
  assign bus.RegWrite    = r_out.reg_write;
  assign bus.MemRead     = r_out.mem_read;
  assign bus.MemWrite    = r_out.mem_write;
  assign bus.IRWrite     = w_fetch_ack;
  assign bus.PCWrite     = r_out.pc_write | w_fetch_ack;
  assign bus.PCWriteCond = r_out.pc_write_cond;
  assign bus.PCSource    = r_out.pc_source;
  assign bus.state       = r_state;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed scoreboard bench for multi_cycle_ctrl.
// Control word packing used for expectations:
//   [13] ALUSrc [12:11] ALUOp [10] RegDst [9] MemtoReg [8] RegWrite
//   [7] MemRead [6] MemWrite [5] IRWrite [4] PCWrite [3] PCWriteCond
//   [2:1] PCSource [0] illegal_op
module tb_multi_cycle_ctrl;
  logic clk;
  logic reset;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_BAD  = 6'b111111;

  localparam logic [13:0] C_ZERO    = 14'b0_00_0_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] C_FETCH   = 14'b0_00_0_0_0_1_0_1_1_0_00_0;
  localparam logic [13:0] C_FETCH_W = 14'b0_00_0_0_0_1_0_0_0_0_00_0;
  localparam logic [13:0] C_EX_I    = 14'b1_00_0_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] C_EX_R    = 14'b0_10_0_0_0_0_0_0_0_0_00_0;
  localparam logic [13:0] C_MEM_LW  = 14'b0_00_0_0_0_1_0_0_0_0_00_0;
  localparam logic [13:0] C_MEM_SW  = 14'b0_00_0_0_0_0_1_0_0_0_00_0;
  localparam logic [13:0] C_WB_LW   = 14'b0_00_0_1_1_0_0_0_0_0_00_0;
  localparam logic [13:0] C_WB_R    = 14'b0_00_1_0_1_0_0_0_0_0_00_0;
  localparam logic [13:0] C_WB_I    = 14'b0_00_0_0_1_0_0_0_0_0_00_0;
  localparam logic [13:0] C_BR      = 14'b0_01_0_0_0_0_0_0_0_1_01_0;
  localparam logic [13:0] C_JMP     = 14'b0_00_0_0_0_0_0_0_1_0_10_0;
  localparam logic [13:0] C_TRAP    = 14'b0_00_0_0_0_0_0_0_0_0_00_1;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [13:0] ctl;
  } exp_t;

  exp_t sb[$];
  int unsigned n_cmp;
  int unsigned n_err;
  string phase;

  logic [13:0] w_obs_ctl;
  assign w_obs_ctl = {bus.ALUSrc, bus.ALUOp, bus.RegDst, bus.MemtoReg, bus.RegWrite,
                      bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite,
                      bus.PCWriteCond, bus.PCSource, bus.illegal_op};

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty obs=%0d exp=>0", sb.size());
    end else begin
      e = sb.pop_front();
      n_cmp++;
      assert (bus.state === e.st) else begin
        n_err++;
        $error("FAIL %s.state obs=%0d exp=%0d", e.tag, bus.state, e.st);
      end
      n_cmp++;
      assert (w_obs_ctl === e.ctl) else begin
        n_err++;
        $error("FAIL %s.ctl obs=%b exp=%b", e.tag, w_obs_ctl, e.ctl);
      end
    end
  endtask

  // Called at posedge+1: drive inputs, record the expected state/controls for
  // this cycle, sample mid-cycle, then advance to the next posedge+1.
  task automatic step(input logic [3:0] st, input logic [13:0] ctl,
                      input logic run, input logic [5:0] op, input logic mr);
    bus.run       = run;
    bus.opcode    = op;
    bus.mem_ready = mr;
    sb.push_back('{phase, st, ctl});
    #2;
    pop_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.run = 1'b0;
    bus.opcode = T_R;
    bus.mem_ready = 1'b0;

    phase = "reset";
    #3;
    sb.push_back('{phase, 4'd0, C_ZERO});
    pop_check();
    @(posedge clk); #1;
    reset = 1'b0;

    phase = "lw";
    step(4'd0, C_ZERO,   1'b1, T_LW, 1'b1);
    step(4'd1, C_FETCH,  1'b1, T_LW, 1'b1);
    step(4'd2, C_ZERO,   1'b1, T_LW, 1'b1);
    step(4'd3, C_EX_I,   1'b1, T_LW, 1'b1);
    step(4'd4, C_MEM_LW, 1'b1, T_LW, 1'b1);
    step(4'd5, C_WB_LW,  1'b1, T_LW, 1'b1);

    phase = "rtype";
    step(4'd1, C_FETCH, 1'b1, T_R, 1'b1);
    step(4'd2, C_ZERO,  1'b1, T_R, 1'b1);
    step(4'd3, C_EX_R,  1'b1, T_R, 1'b1);
    step(4'd5, C_WB_R,  1'b1, T_R, 1'b1);
    phase = "beq";
    step(4'd1, C_FETCH, 1'b1, T_BEQ, 1'b1);
    step(4'd2, C_ZERO,  1'b1, T_BEQ, 1'b1);
    step(4'd6, C_BR,    1'b1, T_BEQ, 1'b1);

    phase = "sw_wait";
    step(4'd1, C_FETCH,  1'b1, T_SW, 1'b1);
    step(4'd2, C_ZERO,   1'b1, T_SW, 1'b1);
    step(4'd3, C_EX_I,   1'b1, T_SW, 1'b1);
    step(4'd4, C_MEM_SW, 1'b1, T_SW, 1'b0);
    step(4'd4, C_MEM_SW, 1'b1, T_SW, 1'b0);
    step(4'd4, C_MEM_SW, 1'b1, T_SW, 1'b0);
    step(4'd4, C_MEM_SW, 1'b1, T_SW, 1'b1);

    phase = "j_fetchwait";
    step(4'd1, C_FETCH_W, 1'b1, T_J, 1'b0);
    step(4'd1, C_FETCH,   1'b1, T_J, 1'b1);
    step(4'd2, C_ZERO,    1'b1, T_J, 1'b1);
    step(4'd7, C_JMP,     1'b1, T_J, 1'b1);

    phase = "addi_stop";
    step(4'd1, C_FETCH, 1'b1, T_ADDI, 1'b1);
    step(4'd2, C_ZERO,  1'b1, T_ADDI, 1'b1);
    step(4'd3, C_EX_I,  1'b0, T_ADDI, 1'b1);
    step(4'd5, C_WB_I,  1'b0, T_ADDI, 1'b1);
    step(4'd0, C_ZERO,  1'b0, T_ADDI, 1'b1);
    step(4'd0, C_ZERO,  1'b0, T_ADDI, 1'b1);
    step(4'd0, C_ZERO,  1'b1, T_SW, 1'b1);

    phase = "sw_reset";
    step(4'd1, C_FETCH,  1'b1, T_SW, 1'b1);
    step(4'd2, C_ZERO,   1'b1, T_SW, 1'b1);
    step(4'd3, C_EX_I,   1'b1, T_SW, 1'b1);
    step(4'd4, C_MEM_SW, 1'b1, T_SW, 1'b0);
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    sb.push_back('{"async_reset", 4'd0, C_ZERO});
    pop_check();
    @(posedge clk); #1;
    reset = 1'b0;
    phase = "post_reset";
    step(4'd0, C_ZERO, 1'b1, T_BAD, 1'b1);

    phase = "illegal";
    step(4'd1, C_FETCH, 1'b1, T_BAD, 1'b1);
    step(4'd2, C_ZERO,  1'b1, T_BAD, 1'b1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    step(4'd8, C_TRAP, 1'b1, T_BAD, 1'b1);
    step(4'd8, C_TRAP, 1'b0, T_LW,  1'b1);
    step(4'd8, C_TRAP, 1'b1, T_LW,  1'b1);
    reset = 1'b1;
    #1;
    sb.push_back('{"trap_reset", 4'd0, C_ZERO});
    pop_check();
    @(posedge clk); #1;
    reset = 1'b0;
`else
    step(4'd1, C_FETCH, 1'b0, T_BAD, 1'b1);
    step(4'd2, C_ZERO,  1'b0, T_BAD, 1'b1);
    step(4'd0, C_ZERO,  1'b0, T_BAD, 1'b1);
    step(4'd0, C_ZERO,  1'b0, T_BAD, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
